morse_pulse_decoder: RTL and testbench

Receive-side stage that sits directly downstream of the Morse encoder and consumes its `DotDashOut`/`NewBitOut` stream. On every `NewBitIn` strobe it samples `DotDashIn` as one 0.5 s unit. It classifies mark runs as dots or dashes and space runs as element or letter gaps, then matches the completed element pattern against the eight-letter table. It reports the 3-bit letter code, or an error. It lets the bench, and a loopback board build, check the encoder end to end.

---
 rtl/morse_pulse_decoder_pkg.sv | 45 ++++
 rtl/morse_pulse_decoder_if.sv | 23 ++
 rtl/morse_pulse_decoder_lookup.sv | 25 ++
 rtl/morse_pulse_decoder.sv | 170 +++++++++++++++++
 tb/tb_morse_pulse_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pulse_decoder_pkg.sv
// Purpose : shared types and letter table for the Morse receive path.
// Contents: FSM state enum, per-letter element length/code table, element limit.
// Latency : n/a (constants only); no backpressure.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARK    = 2'd1,
    SPACE   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int MAX_ELEMENTS = 4;
  localparam int NUM_LETTERS  = 8;

  // Element [k] describes letter code k. Elements shift in at the LSB with
  // dash = 1, so the first element of a letter ends up in the highest used bit.
  // Concatenation order below runs from letter 7 down to letter 0.
  localparam logic [NUM_LETTERS-1:0][2:0] LETTER_LEN = {
    3'd4,  // 7 ....
    3'd3,  // 6 --.
    3'd4,  // 5 ..-.
    3'd1,  // 4 .
    3'd3,  // 3 -..
    3'd4,  // 2 -.-.
    3'd4,  // 1 -...
    3'd2   // 0 .-
  };

  localparam logic [NUM_LETTERS-1:0][3:0] LETTER_CODE = {
    4'b0000,  // 7 ....
    4'b0110,  // 6 --.
    4'b0010,  // 5 ..-.
    4'b0000,  // 4 .
    4'b0100,  // 3 -..
    4'b1010,  // 2 -.-.
    4'b1000,  // 1 -...
    4'b0001   // 0 .-
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_pulse_decoder_if.sv
// Purpose : unit-sample input stream and decoded-letter outputs of the decoder.
// Ports   : DotDashIn/NewBitIn (sample stream), LetterOut/LetterValid/Error/Busy.
// Latency : n/a (wires only); no backpressure, the sample stream cannot be stalled.
interface morse_pulse_decoder_if;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] LetterOut;
  logic       LetterValid;
  logic       Error;
  logic       Busy;

  // Source of samples / consumer of decoded letters.
  modport master (
    output DotDashIn, NewBitIn,
    input  LetterOut, LetterValid, Error, Busy
  );

  // The decoder itself.
  modport slave (
    input  DotDashIn, NewBitIn,
    output LetterOut, LetterValid, Error, Busy
  );
endinterface

// File: rtl/morse_pulse_decoder_lookup.sv
// Purpose : match a completed element pattern against the eight-letter table.
// Ports   : length/code in; match flag and 3-bit letter code out.
// Latency : purely combinational; no backpressure.
module morse_lookup
  import morse_pkg::*;
(
  input  logic [2:0] length,
  input  logic [3:0] code,
  output logic       match,
  output logic [2:0] letter
);

  // Table entries are unique, so at most one iteration can hit.
  always_comb begin
    match  = 1'b0;
    letter = 3'd0;
    for (int k = 0; k < NUM_LETTERS; k++) begin
      if (length == LETTER_LEN[k] && code == LETTER_CODE[k]) begin
        match  = 1'b1;
        letter = 3'(k);
      end
    end
  end

endmodule

// File: rtl/morse_pulse_decoder.sv
// Purpose : decode a unit-sampled Morse mark/space stream into 3-bit letter codes.
// Ports   : ClockIn, Reset (async, active-high); bus = slave side of morse_pulse_decoder_if.
// Latency : LetterValid/Error pulse one cycle after the deciding NewBitIn sample;
//           no backpressure, every strobe is consumed in the cycle it arrives.
module morse_pulse_decoder
  import morse_pkg::*;
#(
  parameter int DASH_UNITS       = 3,
  parameter int LETTER_GAP_UNITS = 3
) (
  input  logic                   ClockIn,
  input  logic                   Reset,
  morse_pulse_decoder_if.slave   bus
);

  // Run counter only needs to reach one past the longest meaningful run.
  localparam int RUN_MAX = max_int(DASH_UNITS, LETTER_GAP_UNITS) + 1;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  typedef logic [RUN_W-1:0] run_t;

  localparam run_t       RUN_ONE    = run_t'(1);
  localparam run_t       RUN_SAT    = run_t'(RUN_MAX);
  localparam run_t       DASH_RUN   = run_t'(DASH_UNITS);
  localparam run_t       DASH_LIMIT = run_t'(DASH_UNITS + 1);
  localparam run_t       GAP_RUN    = run_t'(LETTER_GAP_UNITS);
  localparam logic [2:0] LEN_FULL   = 3'(MAX_ELEMENTS);

  state_t     state_q, state_d;
  run_t       run_q, run_d;
  logic [2:0] len_q, len_d;
  logic [3:0] code_q, code_d;
  logic [2:0] letter_q, letter_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       busy_q;

  run_t       run_inc;
  logic       lk_match;
  logic [2:0] lk_letter;
  logic       is_dot;
  logic       is_dash;

  morse_lookup u_lookup (
    .length (len_q),
    .code   (code_q),
    .match  (lk_match),
    .letter (lk_letter)
  );

  assign run_inc = (run_q == RUN_SAT) ? run_q : run_q + RUN_ONE;
  assign is_dot  = (run_q == RUN_ONE);
  assign is_dash = (run_q == DASH_RUN);

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      run_q    <= '0;
      len_q    <= '0;
      code_q   <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      len_q    <= len_d;
      code_q   <= code_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    len_d    = len_q;
    code_d   = code_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    if (bus.NewBitIn) begin
      unique case (state_q)
        IDLE: begin
          // Leading lows are absorbed; the first mark starts a fresh letter.
          if (bus.DotDashIn) begin
            state_d = MARK;
            run_d   = RUN_ONE;
            len_d   = '0;
            code_d  = '0;
          end
        end

        MARK: begin
          if (bus.DotDashIn) begin
            run_d = run_inc;
            if (run_inc == DASH_LIMIT) begin
              error_d = 1'b1;
              state_d = RECOVER;
              run_d   = '0;
            end
          end else if (!(is_dot || is_dash) || len_q == LEN_FULL) begin
            // Mark length between dot and dash, or one element too many.
            error_d = 1'b1;
            state_d = RECOVER;
            run_d   = '0;
          end else begin
            len_d   = len_q + 3'd1;
            code_d  = {code_q[2:0], is_dash};
            state_d = SPACE;
            // The low that ended the mark is the first unit of the gap.
            run_d   = RUN_ONE;
          end
        end

        SPACE: begin
          if (!bus.DotDashIn) begin
            run_d = run_inc;
            if (run_inc >= GAP_RUN) begin
              if (lk_match) begin
                valid_d  = 1'b1;
                letter_d = lk_letter;
              end else begin
                error_d = 1'b1;
              end
              state_d = IDLE;
              run_d   = '0;
            end
          end else if (run_q == RUN_ONE) begin
            state_d = MARK;
            run_d   = RUN_ONE;
          end else begin
            // Gap too long for an element gap, too short for a letter gap.
            error_d = 1'b1;
            state_d = RECOVER;
            run_d   = '0;
          end
        end

        RECOVER: begin
          // Any mark restarts the count of consecutive lows.
          if (bus.DotDashIn) begin
            run_d = '0;
          end else begin
            run_d = run_inc;
            if (run_inc >= GAP_RUN) begin
              state_d = IDLE;
              run_d   = '0;
            end
          end
        end

        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  assign bus.LetterOut   = letter_q;
  assign bus.LetterValid = valid_q;
  assign bus.Error       = error_q;
  assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_morse_pulse_decoder.sv
// Purpose : self-checking bench for morse_pulse_decoder (vectors, corner sequences, random vs model).
// Latency : checks pulses one cycle after the deciding strobe.
// Backpressure: none in the DUT; stimulus is free-running.
module tb_morse_pulse_decoder;

  localparam int DASH   = 3;
  localparam int GAP    = 3;
  localparam int MAX_EL = 4;

  typedef struct {
    bit         is_err;
    logic [2:0] letter;
    int         at;
  } ev_t;

  typedef struct {
    logic [31:0] bits;    // first sample in bit n-1
    int          n;
    int          nv;
    int          ne;
    int          letter;  // LetterOut after the sequence
    int          first;   // strobe number of first pulse
    int          last;    // strobe number of last pulse
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morse_pulse_decoder_if bus();

  morse_pulse_decoder #(
    .DASH_UNITS       (DASH),
    .LETTER_GAP_UNITS (GAP)
  ) dut (
    .ClockIn (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   strobe_n = 0;
  ev_t  dut_q[$];
  ev_t  model_q[$];
  bit   stim_q[$];
  vec_t vecs[12];

  string PATS[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; pulses seen after the edge are logged with
  // the number of the strobe that caused them.
  task automatic tick(input bit nb, input bit dd);
    ev_t e;
    bus.NewBitIn  = nb;
    bus.DotDashIn = dd;
    if (nb) strobe_n++;
    @(posedge clk);
    #1;
    if (bus.LetterValid || bus.Error) begin
      chk("pulse_exclusive", int'(bus.LetterValid && bus.Error), 0);
      e.is_err = bus.Error;
      e.letter = bus.Error ? 3'd0 : bus.LetterOut;
      e.at     = strobe_n;
      dut_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.NewBitIn  = 1'b0;
    bus.DotDashIn = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dut_q.delete();
    strobe_n = 0;
  endtask

  // Unit stream as the encoder produces it: mark units, one-unit element
  // gaps, a letter gap completed to GAP lows, letter 5 with a leading low.
  task automatic push_letter(input int k);
    if (k == 5) stim_q.push_back(1'b0);
    for (int c = 0; c < PATS[k].len(); c++) begin
      if (PATS[k].getc(c) == ".") stim_q.push_back(1'b1);
      else for (int d = 0; d < DASH; d++) stim_q.push_back(1'b1);
      stim_q.push_back(1'b0);
    end
    for (int g = 1; g < GAP; g++) stim_q.push_back(1'b0);
  endtask

  // Strobes for every queued sample, with 0..max_gap filler cycles between
  // them during which DotDashIn is random noise.
  task automatic play(input int max_gap);
    foreach (stim_q[j]) begin
      tick(1'b1, stim_q[j]);
      repeat ($urandom_range(max_gap)) tick(1'b0, 1'($urandom));
    end
    repeat (3) tick(1'b0, 1'b0);
  endtask

  function automatic int recover_from(input int p0);
    int p;
    int z;
    p = p0;
    z = 0;
    while (p < stim_q.size()) begin
      if (!stim_q[p]) begin
        z++;
        p++;
        if (z == GAP) return p;
      end else begin
        z = 0;
        p++;
      end
    end
    return stim_q.size();
  endfunction

  function automatic void add_ev(input bit is_err, input int letter, input int at);
    ev_t e;
    e.is_err = is_err;
    e.letter = 3'(letter);
    e.at     = at;
    model_q.push_back(e);
  endfunction

  // Reference: parse the sample stream as runs of marks and spaces.
  task automatic run_model();
    int    i;
    int    n;
    int    len_m;
    int    len_z;
    int    hit;
    bit    in_letter;
    string pat;
    model_q.delete();
    n = stim_q.size();
    i = 0;
    while (i < n) begin
      while (i < n && !stim_q[i]) i++;
      if (i >= n) break;
      pat = "";
      in_letter = 1'b1;
      while (in_letter) begin
        len_m = 0;
        while (i + len_m < n && stim_q[i + len_m] && len_m <= DASH) len_m++;
        if (len_m > DASH) begin
          add_ev(1'b1, 0, i + len_m);
          i = recover_from(i + len_m);
          in_letter = 1'b0;
        end else if (i + len_m >= n) begin
          i = n;
          in_letter = 1'b0;
        end else if ((len_m != 1 && len_m != DASH) || pat.len() == MAX_EL) begin
          add_ev(1'b1, 0, i + len_m + 1);
          i = recover_from(i + len_m + 1);
          in_letter = 1'b0;
        end else begin
          if (len_m == 1) pat = {pat, "."};
          else            pat = {pat, "-"};
          len_z = 0;
          while (i + len_m + len_z < n && !stim_q[i + len_m + len_z] && len_z < GAP) len_z++;
          if (len_z == GAP) begin
            hit = -1;
            for (int k = 0; k < 8; k++) if (pat == PATS[k]) hit = k;
            if (hit >= 0) add_ev(1'b0, hit, i + len_m + len_z);
            else          add_ev(1'b1, 0, i + len_m + len_z);
            i = i + len_m + len_z;
            in_letter = 1'b0;
          end else if (i + len_m + len_z >= n) begin
            i = n;
            in_letter = 1'b0;
          end else if (len_z == 1) begin
            i = i + len_m + len_z;
          end else begin
            add_ev(1'b1, 0, i + len_m + len_z + 1);
            i = recover_from(i + len_m + len_z + 1);
            in_letter = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int m;
    chk({tag, "_event_count"}, dut_q.size(), model_q.size());
    m = (dut_q.size() < model_q.size()) ? dut_q.size() : model_q.size();
    for (int j = 0; j < m; j++) begin
      chk({tag, "_kind"}, int'(dut_q[j].is_err), int'(model_q[j].is_err));
      chk({tag, "_at"}, dut_q[j].at, model_q[j].at);
      if (!model_q[j].is_err) chk({tag, "_letter"}, int'(dut_q[j].letter), int'(model_q[j].letter));
    end
  endtask

  initial begin
    int nv;
    int ne;
    int base;

    vecs[0]  = '{32'b10111000,           8,  1, 0, 0, 8,  8};   // A
    vecs[1]  = '{32'b11010001000,        11, 1, 1, 4, 3,  11};  // 2-unit mark, recover, E
    vecs[2]  = '{32'b111011101110111000, 18, 0, 1, 0, 18, 18};  // ---- unmatched
    vecs[3]  = '{32'b1010101010,         10, 0, 1, 0, 10, 10};  // 5th element
    vecs[4]  = '{32'b1111,               4,  0, 1, 0, 4,  4};   // mark too long
    vecs[5]  = '{32'b1001,               4,  0, 1, 0, 4,  4};   // 2-unit gap then mark
    vecs[6]  = '{32'b001000,             6,  1, 0, 4, 6,  6};   // leading zeros, E
    vecs[7]  = '{32'b111011101000,       12, 1, 0, 6, 12, 12};  // --.
    vecs[8]  = '{32'b1010101000,         10, 1, 0, 7, 10, 10};  // ....
    vecs[9]  = '{32'b1110101000,         10, 1, 0, 3, 10, 10};  // -..
    vecs[10] = '{32'b11101011101000,     14, 1, 0, 2, 14, 14};  // -.-.
    vecs[11] = '{32'b0101011101000,      13, 1, 0, 5, 13, 13};  // 0 ..-.

    // Reset values and Busy timing.
    do_reset();
    chk("reset_LetterOut", int'(bus.LetterOut), 0);
    chk("reset_LetterValid", int'(bus.LetterValid), 0);
    chk("reset_Error", int'(bus.Error), 0);
    chk("reset_Busy", int'(bus.Busy), 0);
    tick(1'b0, 1'b1);
    chk("busy_nonstrobe_high", int'(bus.Busy), 0);
    tick(1'b1, 1'b0);
    chk("busy_low_sample", int'(bus.Busy), 0);
    tick(1'b1, 1'b1);
    chk("busy_after_mark", int'(bus.Busy), 1);

    // Directed vectors.
    for (int v = 0; v < 12; v++) begin
      do_reset();
      stim_q.delete();
      for (int b = vecs[v].n - 1; b >= 0; b--) stim_q.push_back(vecs[v].bits[b]);
      play(0);
      nv = 0;
      ne = 0;
      foreach (dut_q[j]) if (dut_q[j].is_err) ne++; else nv++;
      chk($sformatf("vec%0d_valid_count", v), nv, vecs[v].nv);
      chk($sformatf("vec%0d_error_count", v), ne, vecs[v].ne);
      chk($sformatf("vec%0d_LetterOut", v), int'(bus.LetterOut), vecs[v].letter);
      chk($sformatf("vec%0d_first_at", v), (dut_q.size() > 0) ? dut_q[0].at : 0, vecs[v].first);
      chk($sformatf("vec%0d_last_at", v), (dut_q.size() > 0) ? dut_q[dut_q.size()-1].at : 0, vecs[v].last);
    end

    // Encoder loopback: one unit strobe every 4 clocks, level held between.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      stim_q.delete();
      push_letter(k);
      base = dut_q.size();
      foreach (stim_q[j]) begin
        tick(1'b1, stim_q[j]);
        repeat (3) tick(1'b0, stim_q[j]);
      end
      chk($sformatf("loop%0d_count", k), dut_q.size() - base, 1);
      if (dut_q.size() > base) begin
        chk($sformatf("loop%0d_kind", k), int'(dut_q[base].is_err), 0);
        chk($sformatf("loop%0d_letter", k), int'(dut_q[base].letter), k);
      end
    end

    // Reset mid-dash of letter 1 after letter 7 has loaded LetterOut.
    do_reset();
    stim_q.delete();
    push_letter(7);
    play(0);
    chk("pre_reset_LetterOut", int'(bus.LetterOut), 7);
    dut_q.delete();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("mid_dash_Busy", int'(bus.Busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_LetterOut", int'(bus.LetterOut), 0);
    chk("async_reset_Busy", int'(bus.Busy), 0);
    chk("async_reset_pulses", int'(bus.LetterValid | bus.Error), 0);
    chk("aborted_no_pulse", dut_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dut_q.delete();
    strobe_n = 0;
    stim_q.delete();
    push_letter(6);
    play(0);
    chk("after_reset_count", dut_q.size(), 1);
    if (dut_q.size() > 0) begin
      chk("after_reset_letter", int'(dut_q[0].letter), 6);
      chk("after_reset_at", dut_q[0].at, 12);
    end

    // Random streams: letters with occasional noise bursts, back-to-back
    // and again with idle gaps and toggling DotDashIn between strobes.
    for (int r = 0; r < 4; r++) begin
      stim_q.delete();
      for (int l = 0; l < 30; l++) begin
        if ($urandom_range(3) == 0) stim_q.push_back(1'b0);
        push_letter($urandom_range(7));
        if ($urandom_range(4) == 0)
          repeat ($urandom_range(6, 1)) stim_q.push_back(1'($urandom));
      end
      run_model();
      do_reset();
      play(0);
      compare_model($sformatf("rand%0d_b2b", r));
      do_reset();
      play(5);
      compare_model($sformatf("rand%0d_gaps", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
